// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps an 8:1 multiplexer select through channels 0..7,
// samples the multiplexer output once per channel after a programmable settle
// time, and presents the assembled byte downstream with a valid/ready handshake.
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic [2:0] sel,
    output logic       busy,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready
);

    // Reload value for the per-channel settle counter.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] sel_reg,   sel_next;
    logic [7:0] cnt_reg,   cnt_next;
    logic [7:0] cap_reg,   cap_next;
    logic [7:0] data_reg,  data_next;
    logic       valid_reg, valid_next;
    logic       busy_reg,  busy_next;

    // Capture word with the current channel's bit replaced by y; the bit-7
    // sample is folded in here so the final word is complete on the same edge.
    logic [7:0] cap_upd;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cap
            assign cap_upd[gi] = (sel_reg == 3'(gi)) ? y : cap_reg[gi];
        end
    endgenerate

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 3'd0;
            cnt_reg   <= 8'd0;
            cap_reg   <= 8'd0;
            data_reg  <= 8'd0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
            cap_reg   <= cap_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state logic: accept start in IDLE, walk channels in SCAN,
    // wait for the downstream handshake in HOLD.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        cap_next   = cap_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SCAN;
                    busy_next  = 1'b1;
                    sel_next   = 3'd0;
                    cnt_next   = SETTLE_LOAD;
                end
            end
            SCAN: begin
                if (cnt_reg != 8'd0) begin
                    cnt_next = cnt_reg - 8'd1;
                end else begin
                    cap_next = cap_upd;
                    if (sel_reg != 3'd7) begin
                        sel_next = sel_reg + 3'd1;
                        cnt_next = SETTLE_LOAD;
                    end else begin
                        data_next  = cap_upd;
                        valid_next = 1'b1;
                        state_next = HOLD;
                        sel_next   = 3'd0;
                    end
                end
            end
            HOLD: begin
                // start is deliberately ignored here, even on the handshake edge.
                if (valid_reg && ready) begin
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sel   = sel_reg;
    assign busy  = busy_reg;
    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Testbench for mux_scan_sequencer: two instances (settle 0 and settle 3)
// driven by directed scenarios; a scoreboard queue per instance holds the
// expected words and a monitor compares them on each completed handshake.
module tb_mux_scan_sequencer;

    logic       clk;
    logic       rst;

    logic       start0, ready0, y0;
    logic [2:0] sel0;
    logic       busy0, valid0;
    logic [7:0] data0;
    logic [7:0] bank0;

    logic       start1, ready1, y1;
    logic [2:0] sel1;
    logic       busy1, valid1;
    logic [7:0] data1;
    logic [7:0] bank1;
    logic       glitch1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];

    // Combinational multiplexer models feeding y.
    assign y0 = bank0[sel0];
    assign y1 = bank1[sel1] ^ glitch1;

    mux_scan_sequencer #(.SETTLE_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .start(start0), .y(y0), .sel(sel0),
        .busy(busy0), .data(data0), .valid(valid0), .ready(ready0)
    );

    mux_scan_sequencer #(.SETTLE_CYCLES(3)) u1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1), .sel(sel1),
        .busy(busy1), .data(data1), .valid(valid1), .ready(ready1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s value=%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid0(input int maxc, input string name);
        int n;
        n = 0;
        while (!valid0 && n < maxc) begin
            tick();
            n++;
        end
        if (!valid0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for valid after %0d cycles", name, maxc);
        end
    endtask

    // Scoreboard monitor for instance 0: compare on each handshake.
    always @(negedge clk) begin
        if (!rst && valid0 === 1'b1 && ready0 === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                failures++;
                $display("FAIL u0_handshake actual=%0h expected=<none> (unexpected word)", data0);
            end else begin
                logic [7:0] e;
                e = q0.pop_front();
                if (data0 !== e) begin
                    failures++;
                    $display("FAIL u0_handshake actual=%0h expected=%0h", data0, e);
                end else begin
                    $display("ok   u0_handshake data=%0h", data0);
                end
            end
        end
    end

    // Scoreboard monitor for instance 1: compare on each handshake.
    always @(negedge clk) begin
        if (!rst && valid1 === 1'b1 && ready1 === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL u1_handshake actual=%0h expected=<none> (unexpected word)", data1);
            end else begin
                logic [7:0] e;
                e = q1.pop_front();
                if (data1 !== e) begin
                    failures++;
                    $display("FAIL u1_handshake actual=%0h expected=%0h", data1, e);
                end else begin
                    $display("ok   u1_handshake data=%0h", data1);
                end
            end
        end
    end

    initial begin
        logic [7:0] pat [4];
        int last;
        pat[0] = 8'hAA; pat[1] = 8'h55; pat[2] = 8'hAA; pat[3] = 8'h55;

        rst = 1'b1;
        start0 = 1'b0; ready0 = 1'b1; bank0 = 8'h00;
        start1 = 1'b0; ready1 = 1'b1; bank1 = 8'h00; glitch1 = 1'b0;
        tick();
        tick();

        // Reset state.
        chk("rst_sel0", 32'(sel0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_valid0", 32'(valid0), 0);
        chk("rst_data0", 32'(data0), 0);
        chk("rst_sel1", 32'(sel1), 0);
        chk("rst_valid1", 32'(valid1), 0);
        rst = 1'b0;
        tick();

        // Scenario 1: settle 0, bank 1,0,1,1,0,0,1,0 -> 8'h4D after 8 edges.
        bank0 = 8'h4D;
        q0.push_back(8'h4D);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("s1_sel_%0d", k), 32'(sel0), 32'(k));
            chk("s1_busy", 32'(busy0), 1);
            chk("s1_novalid", 32'(valid0), 0);
            tick();
        end
        chk("s1_valid", 32'(valid0), 1);
        chk("s1_data", 32'(data0), 32'h4D);
        chk("s1_sel_hold", 32'(sel0), 0);
        tick();
        chk("s1_valid_drop", 32'(valid0), 0);
        chk("s1_busy_drop", 32'(busy0), 0);

        // Scenario 2: settle 3, y inverted for the first three cycles of each window.
        bank1 = 8'h4D;
        q1.push_back(8'h4D);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int c = 0; c < 4; c++) begin
                glitch1 = (c < 3);
                chk($sformatf("s2_sel_%0d_%0d", k, c), 32'(sel1), 32'(k));
                chk("s2_novalid", 32'(valid1), 0);
                tick();
            end
        end
        glitch1 = 1'b0;
        chk("s2_valid", 32'(valid1), 1);
        chk("s2_data", 32'(data1), 32'h4D);
        tick();
        chk("s2_busy_drop", 32'(busy1), 0);

        // Scenario 3: ready low for 10 cycles with a start pulse in HOLD.
        ready0 = 1'b0;
        bank0 = 8'h4D;
        q0.push_back(8'h4D);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(20, "s3_valid");
        for (int i = 0; i < 10; i++) begin
            chk("s3_valid_hold", 32'(valid0), 1);
            chk("s3_data_hold", 32'(data0), 32'h4D);
            chk("s3_busy_hold", 32'(busy0), 1);
            chk("s3_sel_hold", 32'(sel0), 0);
            start0 = (i == 3);
            tick();
        end
        start0 = 1'b0;
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        chk("s3_valid_drop", 32'(valid0), 0);
        chk("s3_busy_drop", 32'(busy0), 0);
        chk("s3_sel_idle", 32'(sel0), 0);
        tick();
        chk("s3_no_restart", 32'(busy0), 0);

        // Scenario 4: reset at sel=3 mid-scan, then an all-ones bank.
        bank0 = 8'h4D;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        tick();
        chk("s4_sel_mid", 32'(sel0), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s4_rst_sel", 32'(sel0), 0);
        chk("s4_rst_busy", 32'(busy0), 0);
        chk("s4_rst_valid", 32'(valid0), 0);
        chk("s4_rst_data", 32'(data0), 0);
        bank0 = 8'hFF;
        q0.push_back(8'hFF);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(20, "s4_valid");
        chk("s4_data", 32'(data0), 32'hFF);
        tick();

        // Scenario 5: start and ready held high, alternating banks.
        for (int i = 0; i < 4; i++) q0.push_back(pat[i]);
        bank0 = pat[0];
        start0 = 1'b1;
        last = 0;
        for (int i = 0; i < 4; i++) begin
            wait_valid0(20, "s5_valid");
            if (i > 0) chk("s5_period", 32'(cyc - last), 10);
            last = cyc;
            chk($sformatf("s5_data_%0d", i), 32'(data0), 32'(pat[i]));
            if (i < 3) bank0 = pat[i + 1];
            else start0 = 1'b0;
            tick();
            chk("s5_pulse_width", 32'(valid0), 0);
        end
        tick();
        tick();
        chk("s5_idle", 32'(busy0), 0);
        chk("s5_queue_empty", 32'(q0.size()), 0);

        // Scenario 6: data keeps the previous word until the new valid edge.
        bank0 = 8'h3C;
        q0.push_back(8'h3C);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_valid0(20, "s6a_valid");
        chk("s6_first", 32'(data0), 32'h3C);
        tick();
        bank0 = 8'h81;
        q0.push_back(8'h81);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("s6_data_mid_%0d", k), 32'(data0), 32'h3C);
            tick();
        end
        chk("s6_valid", 32'(valid0), 1);
        chk("s6_data_new", 32'(data0), 32'h81);
        tick();
        tick();

        chk("end_q0_empty", 32'(q0.size()), 0);
        chk("end_q1_empty", 32'(q1.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
